// File: rtl/cacheline_burst_adapter.sv
// Splits one 256-bit cacheline read/write into a single 4-beat 64-bit bmem burst
// and reassembles read beats into a full line. All outputs are registered.
module cacheline_burst_adapter #(
    parameter int LINE_WIDTH = 256,
    parameter int BUS_WIDTH  = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] line_addr,
    input  logic                  line_read,
    input  logic                  line_write,
    input  logic [LINE_WIDTH-1:0] line_wdata,
    output logic [LINE_WIDTH-1:0] line_rdata,
    output logic                  line_resp,
    output logic [ADDR_WIDTH-1:0] bmem_addr,
    output logic                  bmem_read,
    output logic                  bmem_write,
    output logic [BUS_WIDTH-1:0]  bmem_wdata,
    input  logic [BUS_WIDTH-1:0]  bmem_rdata,
    input  logic                  bmem_resp,
    output logic                  adapter_error
);

    localparam int BURST_LEN = LINE_WIDTH / BUS_WIDTH;
    localparam int CNT_W     = $clog2(BURST_LEN);
    localparam int OFF_W     = $clog2(LINE_WIDTH / 8);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_BURST,
        ST_WR_BURST,
        ST_DONE
    } state_t;

    state_t                               r_state;
    logic [CNT_W-1:0]                     r_cnt;
    logic [BURST_LEN-1:0][BUS_WIDTH-1:0]  r_rdata;
    logic [BURST_LEN-1:0][BUS_WIDTH-1:0]  r_line_q;
    logic                                 r_resp;
    logic                                 r_error;
    logic [ADDR_WIDTH-1:0]                r_addr;
    logic                                 r_read;
    logic                                 r_write;
    logic [BUS_WIDTH-1:0]                 r_wdata;

    logic [ADDR_WIDTH-1:0]                w_aligned_addr;
    logic [CNT_W-1:0]                     w_next_cnt;
    logic                                 w_last_beat;
    logic                                 w_issue_write;
    logic                                 w_unused_addr_bits;

    // Bursts always start on a line boundary; the byte offset is dropped.
    assign w_aligned_addr     = {line_addr[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
    assign w_unused_addr_bits = ^line_addr[OFF_W-1:0];
    assign w_next_cnt         = r_cnt + CNT_W'(1);
    assign w_last_beat        = (r_cnt == CNT_W'(BURST_LEN - 1));
    assign w_issue_write      = (r_state == ST_IDLE) && line_write && !line_read;

    // NOTE: the line buffer is pure data and is always loaded before it is read,
    // so it has no reset and lives in its own block.
    always_ff @(posedge clk) begin
        if (w_issue_write) begin
            r_line_q <= line_wdata;
        end
    end

    // NOTE: every sequential assignment is non-blocking so all state updates
    // see the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_resp  <= 1'b0;
            r_error <= 1'b0;
            r_addr  <= '0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bmem_resp) begin
                        r_error <= 1'b1;
                    end
                    if (line_read && line_write) begin
                        r_error <= 1'b1;
                    end else if (line_read) begin
                        r_addr  <= w_aligned_addr;
                        r_read  <= 1'b1;
                        r_state <= ST_RD_BURST;
                    end else if (line_write) begin
                        r_addr  <= w_aligned_addr;
                        r_wdata <= line_wdata[BUS_WIDTH-1:0];
                        r_write <= 1'b1;
                        r_state <= ST_WR_BURST;
                    end
                end
                ST_RD_BURST: begin
                    if (bmem_resp) begin
                        r_rdata[r_cnt] <= bmem_rdata;
                        r_cnt          <= w_next_cnt;
                        if (w_last_beat) begin
                            r_read  <= 1'b0;
                            r_resp  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_WR_BURST: begin
                    // Memory samples bmem_wdata at the resp edge, so stage the next beat now.
                    if (bmem_resp) begin
                        r_cnt   <= w_next_cnt;
                        r_wdata <= r_line_q[w_next_cnt];
                        if (w_last_beat) begin
                            r_write <= 1'b0;
                            r_resp  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_resp  <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign line_rdata    = r_rdata;
    assign line_resp     = r_resp;
    assign adapter_error = r_error;
    assign bmem_addr     = r_addr;
    assign bmem_read     = r_read;
    assign bmem_write    = r_write;
    assign bmem_wdata    = r_wdata;

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Bench for cacheline_burst_adapter: burst DRAM model with random latency/gaps,
// and a qword-level reference store for expected line contents.
module tb_cacheline_burst_adapter;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  line_addr = '0;
    logic         line_read = 1'b0;
    logic         line_write = 1'b0;
    logic [255:0] line_wdata = '0;
    logic [255:0] line_rdata;
    logic         line_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic [63:0]  bmem_rdata;
    logic         bmem_resp;
    logic         adapter_error;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cacheline_burst_adapter dut (
        .clk           (clk),
        .rst           (rst),
        .line_addr     (line_addr),
        .line_read     (line_read),
        .line_write    (line_write),
        .line_wdata    (line_wdata),
        .line_rdata    (line_rdata),
        .line_resp     (line_resp),
        .bmem_addr     (bmem_addr),
        .bmem_read     (bmem_read),
        .bmem_write    (bmem_write),
        .bmem_wdata    (bmem_wdata),
        .bmem_rdata    (bmem_rdata),
        .bmem_resp     (bmem_resp),
        .adapter_error (adapter_error)
    );

    // DRAM contents (written only by the DUT) and the bench's own expectation, by qword address.
    logic [63:0] dram    [logic [28:0]];
    logic [63:0] ref_mem [logic [28:0]];

    bit          mem_busy = 0;
    bit          mem_wr = 0;
    bit          mem_err = 0;
    bit          force_resp = 0;
    int          mem_lat = 0;
    int          mem_beat = 0;
    int          last_beat_cyc = 0;
    int          resp_cycles = 0;
    logic [31:0] mem_base = '0;

    function automatic logic [63:0] init_word(logic [28:0] q);
        return {3'b000, q, 3'b111, ~q};
    endfunction

    function automatic logic [255:0] ref_line(logic [31:0] a);
        logic [255:0] l;
        for (int i = 0; i < 4; i++) begin
            logic [28:0] k = {a[31:5], 2'(i)};
            l[64*i +: 64] = ref_mem.exists(k) ? ref_mem[k] : init_word(k);
        end
        return l;
    endfunction

    function automatic logic [255:0] dram_line(logic [31:0] a);
        logic [255:0] l;
        for (int i = 0; i < 4; i++) begin
            logic [28:0] k = {a[31:5], 2'(i)};
            l[64*i +: 64] = dram.exists(k) ? dram[k] : init_word(k);
        end
        return l;
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    // Burst memory: decides resp/rdata at each negedge for the following posedge,
    // and captures write beats while they are stable ahead of that edge.
    initial begin
        logic [28:0] q;
        bmem_resp  = 1'b0;
        bmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                mem_busy   = 0;
                mem_beat   = 0;
                bmem_resp  = 1'b0;
                bmem_rdata = '0;
            end else begin
                if (bmem_read && bmem_write) mem_err = 1;
                bmem_resp = 1'b0;
                if (!mem_busy) begin
                    mem_beat = 0;
                    if (bmem_read || bmem_write) begin
                        mem_busy = 1;
                        mem_wr   = bmem_write;
                        mem_base = bmem_addr;
                        mem_lat  = $urandom_range(0, 3);
                        if (bmem_addr[4:0] != 5'd0) mem_err = 1;
                    end
                end
                if (mem_busy) begin
                    if (bmem_addr !== mem_base || bmem_read !== !mem_wr || bmem_write !== mem_wr)
                        mem_err = 1;
                    if (mem_lat > 0) begin
                        mem_lat--;
                    end else if ($urandom_range(0, 3) != 0) begin
                        bmem_resp = 1'b1;
                        q = mem_base[31:3] + 29'(mem_beat);
                        if (mem_wr) dram[q] = bmem_wdata;
                        else bmem_rdata = dram.exists(q) ? dram[q] : init_word(q);
                        mem_beat++;
                        if (mem_beat == 4) begin
                            mem_busy      = 0;
                            last_beat_cyc = cyc + 1;
                        end
                    end
                end else if (force_resp) begin
                    bmem_resp = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) if (line_resp) resp_cycles++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One line transaction; checks issued command, completion timing and resulting data.
    task automatic line_op(input bit wr, input logic [31:0] addr, input logic [255:0] data);
        int  waited = 0;
        bit  seen_cmd = 0;
        logic [255:0] rd_before = line_rdata;
        line_addr  = addr;
        line_wdata = data;
        line_read  = !wr;
        line_write = wr;
        if (wr) for (int i = 0; i < 4; i++) ref_mem[{addr[31:5], 2'(i)}] = data[64*i +: 64];
        while (!line_resp && waited < 300) begin
            tick();
            waited++;
            if (!seen_cmd && (bmem_read || bmem_write)) begin
                seen_cmd = 1;
                n_checks++;
                if (bmem_addr !== {addr[31:5], 5'd0} || bmem_read !== !wr || bmem_write !== wr)
                    $display("FAIL issue @%h: addr=%h rd=%b wr=%b, want addr=%h rd=%b wr=%b",
                             addr, bmem_addr, bmem_read, bmem_write, {addr[31:5], 5'd0}, !wr, wr);
                else n_pass++;
                line_addr  = $urandom;
                line_wdata = rand_line();
            end
        end
        n_checks++;
        if (!line_resp) $display("FAIL timeout @%h: line_resp=%b after %0d cycles, want 1", addr, line_resp, waited);
        else n_pass++;
        n_checks++;
        if (cyc !== last_beat_cyc)
            $display("FAIL resp_timing @%h: resp seen cycle %0d, want %0d", addr, cyc, last_beat_cyc);
        else n_pass++;
        line_read  = 1'b0;
        line_write = 1'b0;
        if (wr) begin
            n_checks++;
            if (dram_line(addr) !== ref_line(addr))
                $display("FAIL wr_data @%h: dram=%h want %h", addr, dram_line(addr), ref_line(addr));
            else n_pass++;
            n_checks++;
            if (line_rdata !== rd_before)
                $display("FAIL wr_keeps_rdata @%h: line_rdata=%h want %h", addr, line_rdata, rd_before);
            else n_pass++;
        end else begin
            n_checks++;
            if (line_rdata !== ref_line(addr))
                $display("FAIL rd_data @%h: line_rdata=%h want %h", addr, line_rdata, ref_line(addr));
            else n_pass++;
        end
        tick();
        n_checks++;
        if (line_resp !== 1'b0) $display("FAIL resp_pulse @%h: line_resp=%b want 0", addr, line_resp);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({line_rdata, line_resp, adapter_error} !== '0)
            $display("FAIL reset_line: rdata=%h resp=%b err=%b want 0", line_rdata, line_resp, adapter_error);
        else n_pass++;
        n_checks++;
        if ({bmem_addr, bmem_read, bmem_write, bmem_wdata} !== '0)
            $display("FAIL reset_bmem: addr=%h rd=%b wr=%b wdata=%h want 0", bmem_addr, bmem_read, bmem_write, bmem_wdata);
        else n_pass++;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_read();
        int p0;
        logic [63:0] pat [4] = '{64'h1111111111111111, 64'h2222222222222222,
                                 64'h3333333333333333, 64'h4444444444444444};
        for (int i = 0; i < 4; i++) begin
            dram[29'(8 + i)]    = pat[i];
            ref_mem[29'(8 + i)] = pat[i];
        end
        p0 = resp_cycles;
        line_op(0, 32'h40, '0);
        n_checks++;
        if (line_rdata !== {pat[3], pat[2], pat[1], pat[0]})
            $display("FAIL read_0x40: line_rdata=%h want %h", line_rdata, {pat[3], pat[2], pat[1], pat[0]});
        else n_pass++;
        n_checks++;
        if (resp_cycles - p0 !== 1) $display("FAIL read_resp_count: %0d want 1", resp_cycles - p0);
        else n_pass++;
    endtask

    task automatic test_write();
        logic [63:0] a = 64'hAAAA0000AAAA0001, b = 64'hBBBB0000BBBB0002;
        logic [63:0] c = 64'hCCCC0000CCCC0003, d = 64'hDDDD0000DDDD0004;
        line_op(1, 32'h80, {d, c, b, a});
        n_checks++;
        if ({dram[29'h13], dram[29'h12], dram[29'h11], dram[29'h10]} !== {d, c, b, a})
            $display("FAIL write_beats: dram=%h want %h",
                     {dram[29'h13], dram[29'h12], dram[29'h11], dram[29'h10]}, {d, c, b, a});
        else n_pass++;
        line_op(0, 32'h80, '0);
        n_checks++;
        if (mem_err !== 1'b0) $display("FAIL write_mem_err: mem_err=%b want 0", mem_err);
        else n_pass++;
    endtask

    task automatic test_unaligned();
        line_op(0, 32'h12345677, '0);
    endtask

    task automatic test_back_to_back();
        int p0 = resp_cycles;
        line_op(1, 32'h100, rand_line());
        line_op(0, 32'h100, '0);
        line_op(0, 32'h10100, '0);
        n_checks++;
        if (resp_cycles - p0 !== 3) $display("FAIL b2b_resp_count: %0d want 3", resp_cycles - p0);
        else n_pass++;
        n_checks++;
        if (mem_err !== 1'b0) $display("FAIL b2b_mem_err: mem_err=%b want 0", mem_err);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 16; n++) begin
            logic [31:0] a = 32'h1000 + {$urandom_range(0, 7), 5'd0} + 32'($urandom_range(0, 31));
            line_op(bit'($urandom_range(0, 1)), a, rand_line());
        end
    endtask

    task automatic test_reset_mid_read();
        int waited = 0;
        line_addr = 32'h40;
        line_read = 1'b1;
        while (mem_beat != 2 && waited < 300) begin
            tick();
            waited++;
        end
        n_checks++;
        if (mem_beat != 2) $display("FAIL midreset_wait: beats=%0d want 2", mem_beat);
        else n_pass++;
        rst       = 1'b0;
        line_read = 1'b0;
        tick();
        n_checks++;
        if ({line_rdata, line_resp, adapter_error, bmem_addr, bmem_read, bmem_write, bmem_wdata} !== '0)
            $display("FAIL midreset_outputs: rdata=%h resp=%b err=%b addr=%h rd=%b wr=%b want all 0",
                     line_rdata, line_resp, adapter_error, bmem_addr, bmem_read, bmem_write);
        else n_pass++;
        rst = 1'b1;
        tick();
        line_op(0, 32'h40, '0);
    endtask

    task automatic test_protocol();
        line_addr  = 32'h200;
        line_read  = 1'b1;
        line_write = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (adapter_error !== 1'b1 || bmem_read !== 1'b0 || bmem_write !== 1'b0)
            $display("FAIL both_req: err=%b rd=%b wr=%b want 1 0 0", adapter_error, bmem_read, bmem_write);
        else n_pass++;
        line_read  = 1'b0;
        line_write = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (adapter_error !== 1'b1) $display("FAIL err_sticky: err=%b want 1", adapter_error);
        else n_pass++;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if (adapter_error !== 1'b0) $display("FAIL err_clear: err=%b want 0", adapter_error);
        else n_pass++;
        force_resp = 1;
        tick();
        force_resp = 0;
        tick();
        n_checks++;
        if (adapter_error !== 1'b1 || bmem_read !== 1'b0 || bmem_write !== 1'b0)
            $display("FAIL stray_resp: err=%b rd=%b wr=%b want 1 0 0", adapter_error, bmem_read, bmem_write);
        else n_pass++;
        n_checks++;
        if (mem_err !== 1'b0) $display("FAIL final_mem_err: mem_err=%b want 0", mem_err);
        else n_pass++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read();
        test_write();
        test_unaligned();
        test_back_to_back();
        test_random();
        test_reset_mid_read();
        test_protocol();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cacheline_burst_adapter.md
Name: cacheline_burst_adapter

Overview:
- Sits between the L2/last-level cache and the burst DRAM model on the bmem interface.
- Converts a single 256-bit cacheline read or write into one 4-beat, 64-bit burst transaction and reassembles read beats into a full line.
- Keeps every bmem protocol rule: control and address held stable for the whole burst, 32-byte-aligned bursts, no simultaneous read and write.

Parameters:
- LINE_WIDTH, 256: cacheline width in bits.
- BUS_WIDTH, 64: bmem data bus width in bits.
- ADDR_WIDTH, 32: byte address width.
- BURST_LEN, LINE_WIDTH/BUS_WIDTH (localparam, 4): beats per line.

Ports:
- clk  in  1  single clock; all state changes on posedge.
- rst  in  1  synchronous, active-low reset: 0 sampled at posedge resets the block.
- line_addr  in  32  cacheline byte address from cache.
- line_read  in  1  line read request; held until line_resp.
- line_write  in  1  line write request; held until line_resp.
- line_wdata  in  256  write line.
- line_rdata  out  256  assembled read line.
- line_resp  out  1  one-cycle completion pulse.
- bmem_addr  out  32  burst base address.
- bmem_read  out  1  burst read command.
- bmem_write  out  1  burst write command.
- bmem_wdata  out  64  current write beat.
- bmem_rdata  in  64  read beat data.
- bmem_resp  in  1  beat valid/accept strobe from memory.
- adapter_error  out  1  sticky protocol-violation flag.

Behaviour:
- All outputs are registered. Reset values:
  - line_rdata = 0, line_resp = 0, adapter_error = 0.
  - bmem_addr = 0, bmem_read = 0, bmem_write = 0, bmem_wdata = 0.
  - Beat counter = 0, FSM = IDLE.
- FSM states: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE:
  - line_read=1, line_write=0: latch addr with [4:0] forced to 0; bmem_read<=1; go RD_BURST.
  - line_write=1, line_read=0: latch addr the same way; latch line_wdata; bmem_wdata<=beat0 (line_wdata[63:0]); bmem_write<=1; go WR_BURST.
  - Both high: set adapter_error, issue nothing, stay IDLE.
  - bmem_resp=1 while in IDLE: set adapter_error, ignore it.
- RD_BURST:
  - On each posedge with bmem_resp=1, write bmem_rdata into line_rdata[64*cnt +: 64], then cnt++.
  - On the posedge sampling beat 3: bmem_read<=0, line_resp<=1, go DONE.
- WR_BURST:
  - The memory samples bmem_wdata on each posedge where bmem_resp=1, so beat i must be present before its resp edge.
  - On each posedge with bmem_resp=1: cnt++ and bmem_wdata<=line_wdata_q[64*(cnt+1) +: 64].
  - On the posedge sampling beat 3: bmem_write<=0, line_resp<=1, go DONE.
- DONE: line_resp<=0, cnt<=0, go IDLE. Minimum gap between line completions is 1 cycle.
- Latency: line completion is memory latency plus 4 beat cycles plus 1 cycle (DONE).
- line_resp is asserted in the cycle after the last beat edge.
- line_rdata stays valid from line_resp until the next read's first beat; writes do not modify it.
- bmem_addr, bmem_read and bmem_write do not change between issue and the last-beat edge. The memory flags an address change as an error.
- Beat counter is 2 bits and wraps 3->0 only at burst end. bmem_resp gaps mid-burst are tolerated: the counter just holds.
- Changes to line_addr, line_wdata, line_read or line_write during RD_BURST/WR_BURST are ignored; the latched values are used.
- Reset mid-burst returns to IDLE with all outputs at reset values the next cycle. The memory model is reset in the same cycle by the testbench.
- adapter_error clears only on reset.

Test Plan:
- Read: preload mem 0x40..0x5F with qwords 0x1111..., 0x2222..., 0x3333..., 0x4444...; line_read at line_addr=0x40 -> bmem_addr=0x40, bmem_read held 4 beats, line_rdata={0x4444..,0x3333..,0x2222..,0x1111..}, single line_resp pulse.
- Write: line_write at 0x80 with line_wdata = 256'h{D,C,B,A} qwords -> bmem_wdata A,B,C,D on successive resp edges; a later read of 0x80 returns the same line; memory error never set.
- Unaligned address: line_read at 0x12345677 -> bmem_addr=0x12345660; data returned is that line.
- Back-to-back: write 0x100, then read 0x100 immediately, then read a different row in the same bank -> three line_resp pulses, data correct; bmem_read and bmem_write never high together.
- Reset mid-read: assert rst=0 after beat 1 -> next cycle all outputs at reset values and FSM in IDLE; a subsequent read completes normally.
- Protocol: line_read=line_write=1 in IDLE -> adapter_error=1, no bmem command; a stray bmem_resp in IDLE also sets adapter_error.
